// File: rtl/fp_cfg_ctrl.sv
// fp_cfg_ctrl: shadow/active configuration store for the filter pipeline, with drain-then-swap commit.
// Ports: cfg_* is the software write/commit port, pipe_valid_in/out track packets resident in fp,
// hold_in blocks upstream while draining, and choice/kufpu*/bfpu* are the active fp control words.
module fp_cfg_ctrl #(
  parameter int STAGES             = 8,
  parameter int INPUTS             = 2,
  parameter int CHOICE_BITS        = 40,
  parameter int BIT_VEC_SIZE_LOG   = 7,
  parameter int NUM_OF_METRICS_LOG = 4,
  parameter int MAX_INFLIGHT       = 15,
  localparam int CELLS = INPUTS / 2,
  localparam int SW    = STAGES > 1 ? $clog2(STAGES) : 1,
  localparam int CW    = CELLS > 1 ? $clog2(CELLS) : 1,
  localparam int IW    = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  cfg_valid,
  output logic                                                  cfg_ready,
  input  logic [SW-1:0]                                         cfg_stage,
  input  logic [CW-1:0]                                         cfg_cell,
  input  logic [2:0]                                            cfg_field,
  input  logic [31:0]                                           cfg_data,
  input  logic                                                  cfg_commit,
  output logic                                                  commit_done,
  output logic [7:0]                                            cfg_epoch,
  output logic                                                  cfg_err,
  input  logic                                                  cfg_err_clr,
  input  logic                                                  pipe_valid_in,
  input  logic                                                  pipe_valid_out,
  output logic                                                  hold_in,
  output logic [STAGES-1:0][CHOICE_BITS-1:0]                    choice,
  output logic [STAGES-1:0][CELLS-1:0][2:0]                     kufpu1_opcode,
  output logic [STAGES-1:0][CELLS-1:0][BIT_VEC_SIZE_LOG-1:0]    kufpu1_id,
  output logic [STAGES-1:0][CELLS-1:0][NUM_OF_METRICS_LOG-1:0]  kufpu1_metricx,
  output logic [STAGES-1:0][CELLS-1:0][15:0]                    kufpu1_val,
  output logic [STAGES-1:0][CELLS-1:0][2:0]                     kufpu1_pred_op,
  output logic [STAGES-1:0][CELLS-1:0][2:0]                     kufpu2_opcode,
  output logic [STAGES-1:0][CELLS-1:0][BIT_VEC_SIZE_LOG-1:0]    kufpu2_id,
  output logic [STAGES-1:0][CELLS-1:0][NUM_OF_METRICS_LOG-1:0]  kufpu2_metricx,
  output logic [STAGES-1:0][CELLS-1:0][15:0]                    kufpu2_val,
  output logic [STAGES-1:0][CELLS-1:0][2:0]                     kufpu2_pred_op,
  output logic [STAGES-1:0][CELLS-1:0][2:0]                     bfpu1_opcode,
  output logic [STAGES-1:0][CELLS-1:0]                          bfpu1_choice,
  output logic [STAGES-1:0][CELLS-1:0][2:0]                     bfpu2_opcode,
  output logic [STAGES-1:0][CELLS-1:0]                          bfpu2_choice
);
  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;
  state_t state;
  logic [IW-1:0] inflight;
  logic [STAGES-1:0][CHOICE_BITS-1:0]                   sh_choice;
  logic [STAGES-1:0][CELLS-1:0][2:0]                    sh_k1op, sh_k1pr, sh_k2op, sh_k2pr, sh_b1op, sh_b2op;
  logic [STAGES-1:0][CELLS-1:0][BIT_VEC_SIZE_LOG-1:0]   sh_k1id, sh_k2id;
  logic [STAGES-1:0][CELLS-1:0][NUM_OF_METRICS_LOG-1:0] sh_k1mx, sh_k2mx;
  logic [STAGES-1:0][CELLS-1:0][15:0]                   sh_k1v, sh_k2v;
  logic [STAGES-1:0][CELLS-1:0]                         sh_b1ch, sh_b2ch;
  logic wr, bad, inc, dec, ovf, udf;
  assign wr  = cfg_valid & cfg_ready;
  assign bad = (cfg_field == 3'd7) | (32'(cfg_stage) >= STAGES) | (32'(cfg_cell) >= CELLS);
  assign inc = pipe_valid_in & ~pipe_valid_out;
  assign dec = pipe_valid_out & ~pipe_valid_in;
  assign ovf = inc & (inflight == IW'(MAX_INFLIGHT));
  assign udf = dec & (inflight == '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_choice <= '0;
      sh_k1op <= '0; sh_k1id <= '0; sh_k1mx <= '0; sh_k1v <= '0; sh_k1pr <= '0;
      sh_k2op <= '0; sh_k2id <= '0; sh_k2mx <= '0; sh_k2v <= '0; sh_k2pr <= '0;
      sh_b1op <= '0; sh_b1ch <= '0; sh_b2op <= '0; sh_b2ch <= '0;
    end else if (wr && !bad)
      for (int s = 0; s < STAGES; s++)
        if (cfg_stage == SW'(s)) begin
          if (cfg_field == 3'd0) sh_choice[s][31:0] <= cfg_data;
          if (cfg_field == 3'd1) sh_choice[s][CHOICE_BITS-1:32] <= cfg_data[CHOICE_BITS-33:0];
          for (int c = 0; c < CELLS; c++)
            if (cfg_cell == CW'(c)) begin
              if (cfg_field == 3'd2) begin
                sh_k1op[s][c] <= cfg_data[2:0];
                sh_k1id[s][c] <= cfg_data[3 +: BIT_VEC_SIZE_LOG];
                sh_k1mx[s][c] <= cfg_data[12 +: NUM_OF_METRICS_LOG];
                sh_k1pr[s][c] <= cfg_data[18:16];
              end
              if (cfg_field == 3'd3) sh_k1v[s][c] <= cfg_data[15:0];
              if (cfg_field == 3'd4) begin
                sh_k2op[s][c] <= cfg_data[2:0];
                sh_k2id[s][c] <= cfg_data[3 +: BIT_VEC_SIZE_LOG];
                sh_k2mx[s][c] <= cfg_data[12 +: NUM_OF_METRICS_LOG];
                sh_k2pr[s][c] <= cfg_data[18:16];
              end
              if (cfg_field == 3'd5) sh_k2v[s][c] <= cfg_data[15:0];
              if (cfg_field == 3'd6) begin
                sh_b1op[s][c] <= cfg_data[2:0];
                sh_b1ch[s][c] <= cfg_data[3];
                sh_b2op[s][c] <= cfg_data[6:4];
                sh_b2ch[s][c] <= cfg_data[7];
              end
            end
        end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      choice <= '0;
      kufpu1_opcode <= '0; kufpu1_id <= '0; kufpu1_metricx <= '0; kufpu1_val <= '0; kufpu1_pred_op <= '0;
      kufpu2_opcode <= '0; kufpu2_id <= '0; kufpu2_metricx <= '0; kufpu2_val <= '0; kufpu2_pred_op <= '0;
      bfpu1_opcode <= '0; bfpu1_choice <= '0; bfpu2_opcode <= '0; bfpu2_choice <= '0;
    end else if (state == SWAP) begin
      choice <= sh_choice;
      kufpu1_opcode <= sh_k1op; kufpu1_id <= sh_k1id; kufpu1_metricx <= sh_k1mx; kufpu1_val <= sh_k1v; kufpu1_pred_op <= sh_k1pr;
      kufpu2_opcode <= sh_k2op; kufpu2_id <= sh_k2id; kufpu2_metricx <= sh_k2mx; kufpu2_val <= sh_k2v; kufpu2_pred_op <= sh_k2pr;
      bfpu1_opcode <= sh_b1op; bfpu1_choice <= sh_b1ch; bfpu2_opcode <= sh_b2op; bfpu2_choice <= sh_b2ch;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      cfg_ready   <= 1'b1;
      hold_in     <= 1'b0;
      commit_done <= 1'b0;
      cfg_epoch   <= '0;
    end else
      case (state)
        IDLE: if (cfg_commit) begin
          state     <= DRAIN;
          cfg_ready <= 1'b0;
          hold_in   <= 1'b1;
        end
        DRAIN: if (inflight == '0 && !pipe_valid_in) begin
          state       <= SWAP;
          commit_done <= 1'b1;
        end
        SWAP: begin
          state       <= IDLE;
          commit_done <= 1'b0;
          cfg_ready   <= 1'b1;
          hold_in     <= 1'b0;
          cfg_epoch   <= cfg_epoch + 8'd1;
        end
        default: state <= IDLE;
      endcase
  // Packets arriving while hold_in is high still count; only saturation/underflow is an error.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inflight <= '0;
      cfg_err  <= 1'b0;
    end else begin
      inflight <= (inc && !ovf) ? inflight + IW'(1) : (dec && !udf) ? inflight - IW'(1) : inflight;
      cfg_err  <= ((wr && bad) || ovf || udf) ? 1'b1 : cfg_err_clr ? 1'b0 : cfg_err;
    end
endmodule
